ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
// - Execute stage of the 5-stage MIPS pipeline; receiver of id_to_ex_bus.
// - Registers the decode bundle, runs the ALU, drives the data SRAM request for loads/stores.
// - Owns HI/LO and a 32-step iterative divider (DIV/DIVU); stalls the pipe while dividing.
// - Produces ex_to_mem_bus and an identical ex_to_id_bus forwarding copy.
// PARAMETERS
// - none; widths come from lib/defines.vh (`ID_TO_EX_WD=159, `EX_TO_MEM_WD=76, `StallBus=6)
// PORTS
// - clk             in   1    clock, all state on posedge
// - rst             in   1    asynchronous, active-high reset
// - stall           in   6    pipeline stall vector; [2]=ID, [3]=EX; `Stop=1
// - stallreq_for_ex out  1    high while divider busy
// - id_to_ex_bus    in   159  {pc,inst,alu_op[11:0],src1[2:0],src2[3:0],ram_en,ram_wen[3:0],rf_we,rf_waddr[4:0],sel_rf_res,rdata1,rdata2}
// - ex_to_mem_bus   out  76   {pc,ram_en,ram_wen[3:0],sel_rf_res,rf_we,rf_waddr[4:0],result}
// - ex_to_id_bus    out  76   same value as ex_to_mem_bus
// - data_sram_en    out  1    = registered ram_en
// - data_sram_wen   out  4    = registered ram_wen
// - data_sram_addr  out  32   rdata1 + sext(inst[15:0])
// - data_sram_wdata out  32   rdata2
// BEHAVIOUR
// - Input reg: rst -> 0; stall[2]=Stop & stall[3]=NoStop -> 0 (bubble); stall[2]=NoStop -> capture; else hold.
// - src1: [0] rdata1, [1] pc, [2] zext(inst[10:6]). src2: [0] rdata2, [1] sext imm, [2] 32'd8, [3] zext imm.
// - alu_op bits MSB->LSB: add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui; one-hot; all-zero -> result 0.
// - add/sub modulo 2^32, no trap; slt signed, sltu unsigned; shifts by src1[4:0] on src2; lui = {src2[15:0],16'b0}.
// - Combinational path: input reg -> outputs, zero extra latency; outputs are 0 while reg holds a bubble.
// - HI/LO decoded from inst (op 0): mfhi 010000, mflo 010010 -> result=HI/LO; mthi 010001, mtlo 010011
//   write HI/LO from rdata1 at end of cycle when stall[3]=NoStop; div 011010, divu 011011.
// - Reset: HI=LO=0, FSM IDLE, stallreq_for_ex=0, all bus outputs 0.
// - Divider FSM IDLE/RUN/DONE, 5-bit counter cnt:
//   IDLE: div/divu in reg -> latch |a|,|b| (abs only for div) and signs, cnt=0, ->RUN; stallreq=1 this cycle.
//   RUN: one restoring shift-subtract step per cycle, stallreq=1; cnt==31 -> DONE.
//   DONE: stallreq=0; HI=rem, LO=quo written at edge with stall[3]=NoStop, then ->IDLE; else hold DONE.
//   Latency: 34 cycles in EX (1 IDLE + 32 RUN + 1 DONE).
// - Sign fix (div): quo negated if signs differ; rem takes dividend sign. 0x80000000/-1 -> LO=0x80000000, HI=0.
// - Divide by zero: unsigned core result, quo=32'hFFFF_FFFF, rem=|dividend|, then sign fix for div.
// - mfhi/mflo directly behind a div sees the updated HI/LO (div completes before it enters EX).
// - Reset mid-division: FSM to IDLE, partials discarded, HI/LO to 0.
// - Bubble in reg never starts the divider; stallreq_for_ex never asserted in IDLE without div.
// CONFIGURATION
// - EX_DIV_EARLY_EN defined: in IDLE, divisor==0 or |a|<|b| -> skip RUN, go DONE next cycle
//   (quo=0 or 32'hFFFF_FFFF, rem=|a|); latency 2.
// - Undefined: every division takes full 34 cycles; results bit-identical either way.
// TESTING
// - ori $1,$0,0x1234 bubble-free -> ex_to_mem_bus result 0x0000_1234, rf_waddr 1, rf_we 1, same cycle.
// - divu 100/7 then mflo,mfhi -> stallreq high 33 cycles, LO=14, HI=2 read back.
// - div -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF; div 0x80000000/-1 -> LO=0x80000000, HI=0.
// - divu 5/0 -> LO=0xFFFF_FFFF, HI=5; with EX_DIV_EARLY_EN stallreq high 1 cycle only.
// - sw with rdata1=0x1000, imm=0xFFFC -> data_sram_addr 0x0000_0FFC, wdata=rdata2, wen=4'hF.
// - rst asserted at RUN cnt=10 -> outputs 0, stallreq 0 immediately; next div runs full length.

Source files
------------

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage : execute stage of the 5-stage MIPS pipeline.
//
// Registers the decode bundle, runs the ALU, drives the data SRAM request for
// loads/stores, owns HI/LO and a 32-step restoring divider (DIV/DIVU) that
// stalls the pipe while it runs.
//
// Ports
//   clk             in   1    clock, all state on posedge
//   rst             in   1    asynchronous, active-high reset
//   stall           in   6    pipeline stall vector, [2]=ID, [3]=EX, 1=stop
//   stallreq_for_ex out  1    high while the divider is busy
//   id_to_ex_bus    in   159  {pc,inst,alu_op,src1,src2,ram_en,ram_wen,
//                              rf_we,rf_waddr,sel_rf_res,rdata1,rdata2}
//   ex_to_mem_bus   out  76   {pc,ram_en,ram_wen,sel_rf_res,rf_we,rf_waddr,result}
//   ex_to_id_bus    out  76   forwarding copy of ex_to_mem_bus
//   data_sram_en    out  1    registered ram_en
//   data_sram_wen   out  4    registered ram_wen
//   data_sram_addr  out  32   rdata1 + sext(imm)
//   data_sram_wdata out  32   rdata2
//
// Configuration macro
//   EX_DIV_EARLY_EN : divide-by-zero or |a|<|b| skips the iterative phase
//                     (2-cycle latency); results are identical either way.
// ----------------------------------------------------------------------------
module ex_stage (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    output logic         stallreq_for_ex,
    input  logic [158:0] id_to_ex_bus,
    output logic [75:0]  ex_to_mem_bus,
    output logic [75:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_st_e;

    // ------------------------------------------------------------------
    // Input register
    // ------------------------------------------------------------------
    logic [158:0] id_to_ex_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            id_to_ex_q <= '0;
        else if (stall[2] && !stall[3])
            id_to_ex_q <= '0;              // ID held, EX drains: insert bubble
        else if (!stall[2])
            id_to_ex_q <= id_to_ex_bus;
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  src1_sel;
    logic [3:0]  src2_sel;
    logic        ram_en, rf_we, sel_rf_res;
    logic [3:0]  ram_wen;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, src1_sel, src2_sel, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_to_ex_q;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] imm_sext, imm_zext, alu_src1, alu_src2, alu_res;

    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'h0, inst[15:0]};

    always_comb begin
        alu_src1 = '0;
        if (src1_sel[0])      alu_src1 = rdata1;
        else if (src1_sel[1]) alu_src1 = pc;
        else if (src1_sel[2]) alu_src1 = {27'h0, inst[10:6]};

        alu_src2 = '0;
        if (src2_sel[0])      alu_src2 = rdata2;
        else if (src2_sel[1]) alu_src2 = imm_sext;
        else if (src2_sel[2]) alu_src2 = 32'd8;
        else if (src2_sel[3]) alu_src2 = imm_zext;

        // alu_op is one-hot; all-zero (bubble, mthi, div, ...) gives 0
        alu_res = '0;
        case (1'b1)
            alu_op[11]: alu_res = alu_src1 + alu_src2;
            alu_op[10]: alu_res = alu_src1 - alu_src2;
            alu_op[9]:  alu_res = {31'h0, $signed(alu_src1) < $signed(alu_src2)};
            alu_op[8]:  alu_res = {31'h0, alu_src1 < alu_src2};
            alu_op[7]:  alu_res = alu_src1 & alu_src2;
            alu_op[6]:  alu_res = ~(alu_src1 | alu_src2);
            alu_op[5]:  alu_res = alu_src1 | alu_src2;
            alu_op[4]:  alu_res = alu_src1 ^ alu_src2;
            alu_op[3]:  alu_res = alu_src2 << alu_src1[4:0];
            alu_op[2]:  alu_res = alu_src2 >> alu_src1[4:0];
            alu_op[1]:  alu_res = $signed(alu_src2) >>> alu_src1[4:0];
            alu_op[0]:  alu_res = {alu_src2[15:0], 16'h0};
            default:    alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // HI/LO instruction decode
    // ------------------------------------------------------------------
    logic is_special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, is_divu;

    assign is_special = (inst[31:26] == 6'b000000);
    assign is_mfhi    = is_special && (inst[5:0] == 6'b010000);
    assign is_mthi    = is_special && (inst[5:0] == 6'b010001);
    assign is_mflo    = is_special && (inst[5:0] == 6'b010010);
    assign is_mtlo    = is_special && (inst[5:0] == 6'b010011);
    assign is_div     = is_special && (inst[5:0] == 6'b011010);
    assign is_divu    = is_special && (inst[5:0] == 6'b011011);

    // ------------------------------------------------------------------
    // Divider and HI/LO
    // ------------------------------------------------------------------
    div_st_e     st_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;        // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q;        // |divisor|
    logic [31:0] rem_q;        // partial remainder
    logic        neg_quo_q, neg_rem_q;
    logic [31:0] hi_q, lo_q;

    logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [32:0] r_sh, r_diff;
    logic        r_ge;

    assign abs_a = (is_div && rdata1[31]) ? -rdata1 : rdata1;
    assign abs_b = (is_div && rdata2[31]) ? -rdata2 : rdata2;

    // one restoring step: bring in the next dividend bit, subtract if it fits
    assign r_sh   = {rem_q, dvd_q[31]};
    assign r_diff = r_sh - {1'b0, dvs_q};
    assign r_ge   = (r_sh >= {1'b0, dvs_q});

    assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    // IDLE term is combinational: the stall must be seen in the very cycle
    // the division enters EX.
    assign stallreq_for_ex = (st_q == RUN) || ((st_q == IDLE) && (is_div || is_divu));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (st_q)
                IDLE: begin
                    if (is_div || is_divu) begin
                        dvd_q     <= abs_a;
                        dvs_q     <= abs_b;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= is_div && (rdata1[31] ^ rdata2[31]);
                        neg_rem_q <= is_div && rdata1[31];
`ifdef EX_DIV_EARLY_EN
                        if (abs_b == 32'h0 || abs_a < abs_b) begin
                            // quotient is all ones (b==0) or zero; remainder is |a|
                            dvd_q <= (abs_b == 32'h0) ? 32'hFFFF_FFFF : 32'h0;
                            rem_q <= abs_a;
                            st_q  <= DONE;
                        end else begin
                            st_q  <= RUN;
                        end
`else
                        st_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    rem_q <= r_ge ? r_diff[31:0] : r_sh[31:0];
                    dvd_q <= {dvd_q[30:0], r_ge};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        st_q <= DONE;
                end
                DONE: begin
                    if (!stall[3]) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                        st_q <= IDLE;
                    end
                end
                default: st_q <= IDLE;
            endcase

            if (is_mthi && !stall[3]) hi_q <= rdata1;
            if (is_mtlo && !stall[3]) lo_q <= rdata1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [31:0] ex_result;

    assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_id_bus    = ex_to_mem_bus;
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = rdata1 + imm_sext;
    assign data_sram_wdata = rdata2;

    logic unused_ok;
    assign unused_ok = ^{stall[5:4], stall[1:0], inst[25:16], r_diff[32]};

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [5:0]   ext_stall;
    logic         stallreq_for_ex;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus, ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .stallreq_for_ex (stallreq_for_ex),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    // simple stall controller: EX stall request freezes IF/ID/EX
    assign stall = {2'b00, {4{stallreq_for_ex}}} | ext_stall;

    typedef struct {
        logic [75:0] bus;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] hi_m  = 0;
    logic [31:0] lo_m  = 0;

    // ---------------- reference model ----------------
    // op index: 0 add 1 sub 2 slt 3 sltu 4 and 5 nor 6 or 7 xor 8 sll 9 srl 10 sra 11 lui
    function automatic logic [31:0] alu_model(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << a[4:0];
            9:  return b >> a[4:0];
            10: return $signed(b) >>> a[4:0];
            11: return {b[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r, output int stalls);
        longint sa, sb, la, lb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        la = (sa < 0) ? -sa : sa;
        lb = (sb < 0) ? -sb : sb;
        if (b == 32'h0) begin
            q = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
`ifdef EX_DIV_EARLY_EN
        stalls = (lb == 0 || la < lb) ? 1 : 33;
`else
        stalls = 33;
`endif
    endtask

    function automatic logic [158:0] mkbus(input logic [31:0] pc, input logic [31:0] inst,
            input int op, input int s1, input int s2, input logic ren, input logic [3:0] wen,
            input logic we, input logic [4:0] wa, input logic sel,
            input logic [31:0] r1, input logic [31:0] r2);
        logic [11:0] opv;
        logic [2:0]  s1v;
        logic [3:0]  s2v;
        opv = (op >= 0 && op < 12) ? (12'h800 >> op) : 12'h000;
        s1v = (s1 >= 0 && s1 < 3) ? 3'(1 << s1) : 3'b000;
        s2v = (s2 >= 0 && s2 < 4) ? 4'(1 << s2) : 4'b0000;
        return {pc, inst, opv, s1v, s2v, ren, wen, we, wa, sel, r1, r2};
    endfunction

    function automatic logic [31:0] inst_r(input logic [5:0] fn);
        return {6'h00, 20'($urandom), fn};
    endfunction

    // ---------------- driver ----------------
    task automatic cap_wait(input bit want_bubble, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hit = want_bubble ? !stall[3] : !stall[2];
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL capture_timeout: instruction not accepted within 300 cycles");
        end
    endtask

    task automatic send(input int op, input int s1, input int s2, input logic [31:0] inst,
                        input logic [31:0] r1, input logic [31:0] r2, input logic ren,
                        input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic sel);
        logic [31:0] pc, a, b, res, q, r, imm_s;
        logic [5:0]  fn;
        bit          rt, ok;
        exp_t        e;
        pc    = $urandom & 32'hFFFF_FFFC;
        imm_s = {{16{inst[15]}}, inst[15:0]};
        case (s1)
            0: a = r1;
            1: a = pc;
            2: a = {27'h0, inst[10:6]};
            default: a = 32'h0;
        endcase
        case (s2)
            0: b = r2;
            1: b = imm_s;
            2: b = 32'd8;
            3: b = {16'h0, inst[15:0]};
            default: b = 32'h0;
        endcase
        res      = alu_model(op, a, b);
        rt       = (inst[31:26] == 6'h00);
        fn       = inst[5:0];
        e.stalls = 0;
        if (rt && fn == 6'h10) res = hi_m;
        if (rt && fn == 6'h12) res = lo_m;
        if (rt && fn == 6'h11) hi_m = r1;
        if (rt && fn == 6'h13) lo_m = r1;
        if (rt && (fn == 6'h1a || fn == 6'h1b)) begin
            div_model(fn == 6'h1a, r1, r2, q, r, e.stalls);
            hi_m = r;
            lo_m = q;
        end
        e.bus   = {pc, ren, wen, sel, we, wa, res};
        e.en    = ren;
        e.wen   = wen;
        e.addr  = r1 + imm_s;
        e.wdata = r2;
        id_to_ex_bus = mkbus(pc, inst, op, s1, s2, ren, wen, we, wa, sel, r1, r2);
        cap_wait(1'b0, ok);
        if (ok) exp_q.push_back(e);
    endtask

    task automatic bubble();
        bit   ok;
        exp_t e;
        ext_stall = 6'b000100;
        cap_wait(1'b1, ok);
        ext_stall = 6'b000000;
        e.bus = '0; e.en = 1'b0; e.wen = '0; e.addr = '0; e.wdata = '0; e.stalls = 0;
        if (ok) exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [75:0] act, input logic [75:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results never produced", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   scnt;
        exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                scnt = 0;
            end else begin
                if (stallreq_for_ex) scnt++;
                if (!stall[3] && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    if (ex_to_mem_bus !== e.bus || ex_to_id_bus !== e.bus ||
                        data_sram_en !== e.en || data_sram_wen !== e.wen ||
                        data_sram_addr !== e.addr || data_sram_wdata !== e.wdata ||
                        scnt != e.stalls) begin
                        bad++;
                        $display("FAIL ex_out: bus=%h want=%h id_bus=%h sram=%b/%h/%h/%h want=%b/%h/%h/%h stalls=%0d want=%0d",
                                 ex_to_mem_bus, e.bus, ex_to_id_bus,
                                 data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                                 e.en, e.wen, e.addr, e.wdata, scnt, e.stalls);
                    end
                    scnt = 0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        rst          = 1'b1;
        ext_stall    = '0;
        id_to_ex_bus = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_bus", ex_to_mem_bus, 76'h0);
        chk("rst_id_bus", ex_to_id_bus, 76'h0);
        chk("rst_stallreq", {75'h0, stallreq_for_ex}, 76'h0);
        chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // directed: ori $1,$0,0x1234
        send(6, 0, 3, {6'h0d, 5'd0, 5'd1, 16'h1234}, 32'h0, $urandom, 1'b0, 4'h0, 1'b1, 5'd1, 1'b0);
        // divu 100/7, mflo, mfhi
        send(-1, 0, 0, inst_r(6'h1b), 32'd100, 32'd7, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0);
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        // div -7/2
        send(-1, 0, 0, inst_r(6'h1a), 32'hFFFF_FFF9, 32'd2, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0);
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        // div 0x80000000 / -1
        send(-1, 0, 0, inst_r(6'h1a), 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0);
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        // divu 5/0
        send(-1, 0, 0, inst_r(6'h1b), 32'd5, 32'd0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0);
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        // sw with base 0x1000, offset -4
        send(0, 0, 1, {6'h2b, 5'd2, 5'd3, 16'hFFFC}, 32'h1000, 32'hCAFE_F00D, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0);
        // mthi / mtlo then read back
        send(-1, 0, 0, inst_r(6'h11), 32'h1357_9BDF, $urandom, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h13), 32'h2468_ACE0, $urandom, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(4, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd4, 1'b1);
        send(7, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd5, 1'b1);

        // random mix
        for (int n = 0; n < 200; n++) begin
            int k;
            if ($urandom_range(0, 7) == 0) bubble();
            k = $urandom_range(0, 9);
            case (k)
                0, 1, 2:
                    send($urandom_range(0, 11), $urandom_range(0, 2), $urandom_range(0, 3),
                         {6'($urandom_range(1, 63)), 26'($urandom)}, $urandom, $urandom,
                         1'b0, 4'h0, 1'($urandom), 5'($urandom), 1'b0);
                3:
                    send(0, 0, 1, {6'($urandom_range(32, 43)), 26'($urandom)}, $urandom, $urandom,
                         1'b1, 4'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
                4: send(-1, 0, 0, inst_r(6'h11), $urandom, $urandom, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
                5: send(-1, 0, 0, inst_r(6'h13), $urandom, $urandom, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
                6: send($urandom_range(0, 11), $urandom_range(0, 2), $urandom_range(0, 3),
                        inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'($urandom), 1'b0);
                7: send($urandom_range(0, 11), $urandom_range(0, 2), $urandom_range(0, 3),
                        inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'($urandom), 1'b0);
                8: send(-1, 0, 0, inst_r(6'h1a), pick_opnd(), pick_opnd(), 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
                default:
                    send(-1, 0, 0, inst_r(6'h1b), pick_opnd(), pick_opnd(), 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
            endcase
        end
        id_to_ex_bus = '0;
        drain();

        // reset in the middle of a long division
        id_to_ex_bus = mkbus(32'h0, inst_r(6'h1b), -1, 0, 0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                             32'hDEAD_BEEF, 32'd3);
        cap_wait(1'b0, ok);
        id_to_ex_bus = '0;
        repeat (12) @(negedge clk);
        chk("div_busy_before_rst", {75'h0, stallreq_for_ex}, 76'h1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_bus", ex_to_mem_bus, 76'h0);
        chk("midrst_stallreq", {75'h0, stallreq_for_ex}, 76'h0);
        chk("midrst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
        hi_m = 32'h0;
        lo_m = 32'h0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // HI/LO cleared, then a full-length division
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd7, 1'b0);
        send(-1, 0, 0, inst_r(6'h1b), 32'hDEAD_BEEF, 32'd3, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0);
        send(-1, 0, 0, inst_r(6'h12), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0);
        send(-1, 0, 0, inst_r(6'h10), $urandom, $urandom, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        id_to_ex_bus = '0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
